// File: rtl/fifo_rd_ptr_empty.sv
// Read-side pointer and status block of the asynchronous FIFO (rd_clk domain).
// Keeps the binary and Gray read pointers, drives the memory read address and
// derives empty, fill level and sticky underflow from the synchronized Gray
// write pointer.
// Optional feature macro: RD_ALMOST_EMPTY_EN enables the almost-empty
// comparator against AE_Level. Without it rd_almost_empty is tied to 0.
module fifo_rd_ptr_empty #(
    parameter int Addr_Width = 8,
    parameter int AE_Level   = 4
) (
    input  logic                  rd_clk,
    input  logic                  rd_rstn,
    input  logic                  rd_en,
    input  logic [Addr_Width:0]   wr_ptr_sync,
    input  logic                  uf_clr,
    output logic [Addr_Width:0]   rd_ptr,
    output logic [Addr_Width-1:0] rd_addr,
    output logic                  rd_empty,
    output logic                  rd_almost_empty,
    output logic [Addr_Width:0]   rd_count,
    output logic                  rd_underflow
);

    logic                rd_fire;
    logic [Addr_Width:0] rd_bin;
    logic [Addr_Width:0] rd_bin_next;
    logic [Addr_Width:0] rd_gray_next;
    logic [Addr_Width:0] wr_bin_sync;
    logic [Addr_Width:0] rd_count_next;

    // A read only consumes a word when the registered flag says one exists.
    assign rd_fire      = rd_en & ~rd_empty;
    assign rd_bin_next  = rd_bin + {{Addr_Width{1'b0}}, rd_fire};
    assign rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1);

    // Gray-to-binary of the synchronized write pointer: prefix XOR from the MSB.
    always_comb begin
        wr_bin_sync             = '0;
        wr_bin_sync[Addr_Width] = wr_ptr_sync[Addr_Width];
        for (int i = Addr_Width - 1; i >= 0; i--) begin
            wr_bin_sync[i] = wr_bin_sync[i+1] ^ wr_ptr_sync[i];
        end
    end

    // Wrap bit makes the difference exact for a full FIFO (count = depth).
    assign rd_count_next = wr_bin_sync - rd_bin_next;

    // Pointer, address, level and empty flag all use the post-read pointer so
    // empty asserts on the same edge as the last read.
    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            rd_bin   <= '0;
            rd_ptr   <= '0;
            rd_addr  <= '0;
            rd_count <= '0;
            rd_empty <= 1'b1;
        end else begin
            rd_bin   <= rd_bin_next;
            rd_ptr   <= rd_gray_next;
            rd_addr  <= rd_bin_next[Addr_Width-1:0];
            rd_count <= rd_count_next;
            rd_empty <= (rd_gray_next == wr_ptr_sync);
        end
    end

    // Sticky underflow; a new underflow in the clear cycle keeps it set.
    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn)
            rd_underflow <= 1'b0;
        else if (rd_en && rd_empty)
            rd_underflow <= 1'b1;
        else if (uf_clr)
            rd_underflow <= 1'b0;
    end

`ifdef RD_ALMOST_EMPTY_EN
    localparam logic [Addr_Width:0] AE_THRESH = (Addr_Width+1)'(AE_Level);

    // Almost-empty tracks the same next-level value that rd_count registers.
    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn)
            rd_almost_empty <= 1'b1;
        else
            rd_almost_empty <= (rd_count_next <= AE_THRESH);
    end
`else
    assign rd_almost_empty = 1'b0;
`endif

endmodule
